// File: rtl/serial_pair_transmitter_msb_first_if.sv
// serial_pair_transmitter_msb_first_if: word-pair input handshake and serial output bundle (SER_EXPECT_EN adds expect flags)
interface serial_pair_transmitter_msb_first_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic cmp_rst;
  logic out_valid;
  logic out_last;
  logic a_out;
  logic b_out;
`ifdef SER_EXPECT_EN
  logic exp_a_less_b;
  logic exp_a_eq_b;
  logic exp_a_greater_b;
  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, cmp_rst, out_valid, out_last, a_out, b_out,
    input  exp_a_less_b, exp_a_eq_b, exp_a_greater_b
  );
  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, cmp_rst, out_valid, out_last, a_out, b_out,
    output exp_a_less_b, exp_a_eq_b, exp_a_greater_b
  );
`else
  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, cmp_rst, out_valid, out_last, a_out, b_out
  );
  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, cmp_rst, out_valid, out_last, a_out, b_out
  );
`endif
endinterface

// File: rtl/serial_pair_transmitter_msb_first.sv
// serial_pair_transmitter_msb_first: shifts accepted word pairs out MSB first after a cmp_rst pulse (SER_EXPECT_EN adds expect flags)
module serial_pair_transmitter_msb_first #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input logic clk,
  input logic rst_n,
  serial_pair_transmitter_msb_first_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0] cnt;
  logic [3:0] gcnt;
  // Frame sequencer: accept, comparator reset pulse, MSB-first shift, inter-frame gap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.cmp_rst   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.a_out     <= 1'b0;
      bus.b_out     <= 1'b0;
`ifdef SER_EXPECT_EN
      bus.exp_a_less_b    <= 1'b0;
      bus.exp_a_eq_b      <= 1'b1;
      bus.exp_a_greater_b <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_ready && bus.in_valid) begin
            state        <= LOAD;
            bus.in_ready <= 1'b0;
            bus.cmp_rst  <= 1'b1;
            sa           <= bus.in_a;
            sb           <= bus.in_b;
            cnt          <= CW'(WIDTH - 1);
`ifdef SER_EXPECT_EN
            bus.exp_a_less_b    <= bus.in_a < bus.in_b;
            bus.exp_a_eq_b      <= bus.in_a == bus.in_b;
            bus.exp_a_greater_b <= bus.in_a > bus.in_b;
`endif
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        LOAD: begin
          state         <= SHIFT;
          bus.cmp_rst   <= 1'b0;
          bus.out_valid <= 1'b1;
          bus.out_last  <= 1'b0;
          bus.a_out     <= sa[WIDTH-1];
          bus.b_out     <= sb[WIDTH-1];
          sa            <= sa << 1;
          sb            <= sb << 1;
        end
        SHIFT: begin
          if (cnt == '0) begin
            state         <= (GAP_CYCLES == 0) ? IDLE : GAP;
            bus.in_ready  <= GAP_CYCLES == 0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.a_out     <= 1'b0;
            bus.b_out     <= 1'b0;
            gcnt          <= 4'(GAP_CYCLES - 1);
          end else begin
            cnt          <= cnt - CW'(1);
            bus.out_last <= cnt == CW'(1);
            bus.a_out    <= sa[WIDTH-1];
            bus.b_out    <= sb[WIDTH-1];
            sa           <= sa << 1;
            sb           <= sb << 1;
          end
        end
        GAP: begin
          if (gcnt == 4'd0) begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
          end else begin
            gcnt <= gcnt - 4'd1;
          end
        end
      endcase
    end
  end
endmodule
